// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with one outstanding bus request,
// ID-stall buffering, flush discard and branch/delay-slot tracking.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_stall_i,
  input  logic        if_flush_i,
  input  logic [31:0] if_flush_pc_i,
  input  logic        if_branch_en_i,
  input  logic [31:0] if_branch_pc_i,
  input  logic        if_next_inslot_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_inslot_o,
  output logic        if_valid_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_inslot_q, out_inslot_d;
  logic        out_valid_q, out_valid_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_inslot_q, pend_inslot_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;

  logic        id_accept;
  logic        deliver;
  logic [31:0] dlv_pc;
  logic [31:0] dlv_inst;

  // ID only acts on decoder outputs when it holds a real instruction and is not stalled.
  assign id_accept = out_valid_q & ~if_stall_i;
  assign deliver   = ~if_flush_i & ~if_stall_i &
                     (((state_q == S_WAIT) & inst_data_ok_i) | (state_q == S_HOLD));
  assign dlv_pc    = (state_q == S_HOLD) ? buf_pc_q   : pc_q;
  assign dlv_inst  = (state_q == S_HOLD) ? buf_inst_q : inst_rdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (if_flush_i) begin
      // A flushed request that is still in flight must have its data swallowed.
      case (state_q)
        S_REQ:   state_d = inst_addr_ok_i ? S_DISCARD : S_REQ;
        S_HOLD:  state_d = S_REQ;
        default: state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
      endcase
    end else begin
      case (state_q)
        S_REQ:     if (inst_addr_ok_i) state_d = S_WAIT;
        S_WAIT:    if (inst_data_ok_i) state_d = if_stall_i ? S_HOLD : S_REQ;
        S_HOLD:    if (!if_stall_i) state_d = S_REQ;
        S_DISCARD: if (inst_data_ok_i) state_d = S_REQ;
        default:   state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    inst_req_o  = rst_n & (state_q == S_REQ);
    inst_addr_o = pc_q;
  end

  always_comb begin
    pc_d          = pc_q;
    out_pc_d      = out_pc_q;
    out_inst_d    = out_inst_q;
    out_inslot_d  = out_inslot_q;
    out_valid_d   = out_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    pend_inslot_d = pend_inslot_q;
    buf_pc_d      = buf_pc_q;
    buf_inst_d    = buf_inst_q;
    if (if_flush_i) begin
      pc_d          = if_flush_pc_i;
      out_inst_d    = 32'h0;
      out_inslot_d  = 1'b0;
      out_valid_d   = 1'b0;
      pend_valid_d  = 1'b0;
      pend_inslot_d = 1'b0;
    end else if (deliver) begin
      out_pc_d      = dlv_pc;
      out_inst_d    = dlv_inst;
      out_valid_d   = 1'b1;
      out_inslot_d  = (id_accept & if_next_inslot_i) | pend_inslot_q;
      if (id_accept & if_branch_en_i) begin
        pc_d = if_branch_pc_i;
      end else if (pend_valid_q) begin
        pc_d = pend_pc_q;
      end else begin
        pc_d = dlv_pc + 32'd4;
      end
      pend_valid_d  = 1'b0;
      pend_inslot_d = 1'b0;
    end else begin
      if (!if_stall_i) begin
        out_inst_d   = 32'h0;
        out_inslot_d = 1'b0;
        out_valid_d  = 1'b0;
      end
      if (id_accept & if_branch_en_i) begin
        pend_valid_d = 1'b1;
        pend_pc_d    = if_branch_pc_i;
      end
      if (id_accept & if_next_inslot_i) begin
        pend_inslot_d = 1'b1;
      end
      // Data arriving in WAIT without a delivery means ID is stalled: park it.
      if ((state_q == S_WAIT) & inst_data_ok_i) begin
        buf_pc_d   = pc_q;
        buf_inst_d = inst_rdata_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      out_pc_q      <= 32'h0;
      out_inst_q    <= 32'h0;
      out_inslot_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= 32'h0;
      pend_inslot_q <= 1'b0;
      buf_pc_q      <= 32'h0;
      buf_inst_q    <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      out_pc_q      <= out_pc_d;
      out_inst_q    <= out_inst_d;
      out_inslot_q  <= out_inslot_d;
      out_valid_q   <= out_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
      pend_inslot_q <= pend_inslot_d;
      buf_pc_q      <= buf_pc_d;
      buf_inst_q    <= buf_inst_d;
    end
  end

  assign if_pc_o     = out_pc_q;
  assign if_inst_o   = out_inst_q;
  assign if_inslot_o = out_inslot_q;
  assign if_valid_o  = out_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] RST_PC   = 32'hBFC0_0000;
  localparam logic [31:0] MEM_KEY  = 32'h2408_0001;
  localparam int          N_CYCLES = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_stall_i = 1'b0;
  logic        if_flush_i = 1'b0;
  logic [31:0] if_flush_pc_i = 32'h0;
  logic        if_branch_en_i = 1'b0;
  logic [31:0] if_branch_pc_i = 32'h0;
  logic        if_next_inslot_i = 1'b0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = 32'h0;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_inslot_o;
  logic        if_valid_o;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_stall_i       (if_stall_i),
    .if_flush_i       (if_flush_i),
    .if_flush_pc_i    (if_flush_pc_i),
    .if_branch_en_i   (if_branch_en_i),
    .if_branch_pc_i   (if_branch_pc_i),
    .if_next_inslot_i (if_next_inslot_i),
    .inst_req_o       (inst_req_o),
    .inst_addr_o      (inst_addr_o),
    .inst_addr_ok_i   (inst_addr_ok_i),
    .inst_data_ok_i   (inst_data_ok_i),
    .inst_rdata_i     (inst_rdata_i),
    .if_pc_o          (if_pc_o),
    .if_inst_o        (if_inst_o),
    .if_inslot_o      (if_inslot_o),
    .if_valid_o       (if_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        slot;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_consumed = 0;
  bit   running = 1'b0;

  // Program image and decoder rules: every word is a function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ MEM_KEY;
  endfunction

  function automatic logic is_branch(input logic [31:0] w);
    return (w[4:2] == 3'b011) || (w[4:2] == 3'b110);
  endfunction

  function automatic logic is_taken(input logic [31:0] w);
    return w[7];
  endfunction

  function automatic logic [31:0] target_of(input logic [31:0] w);
    return RST_PC + {20'd0, w[13:4], 2'b00};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: ID consumes an instruction whenever it is valid and neither stalled nor flushed.
  always @(negedge clk) begin
    exp_t e;
    if (running && rst_n) begin
      if (if_valid_o && !if_stall_i && !if_flush_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_inst: got pc %h with no instruction expected", if_pc_o);
        end else begin
          e = exp_q.pop_front();
          check32("if_pc_o", if_pc_o, e.pc);
          check32("if_inst_o", if_inst_o, mem_word(e.pc));
          check32("if_inslot_o", {31'd0, if_inslot_o}, {31'd0, e.slot});
          n_consumed++;
        end
      end else if (!if_valid_o) begin
        check32("bubble_inst_inslot", {if_inslot_o, if_inst_o[30:0]} | {31'd0, if_inst_o[31]}, 32'h0);
      end
    end
  end

  initial begin
    logic        out_valid;
    logic [31:0] out_addr;
    int          out_lat;
    logic [31:0] acc_addr;
    int          stall_left;
    logic [31:0] fpc;
    logic [31:0] w;
    logic [31:0] m_after;
    exp_t        m_cur;
    exp_t        nxt;
    bit          calm;

    out_valid  = 1'b0;
    out_addr   = 32'h0;
    out_lat    = 0;
    acc_addr   = 32'h0;
    stall_left = 0;
    m_after    = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check32("rst_if_pc_o", if_pc_o, 32'h0);
    check32("rst_if_inst_o", if_inst_o, 32'h0);
    check32("rst_if_inslot_o", {31'd0, if_inslot_o}, 32'h0);
    check32("rst_if_valid_o", {31'd0, if_valid_o}, 32'h0);
    check32("rst_inst_req_o", {31'd0, inst_req_o}, 32'h0);
    check32("rst_inst_addr_o", inst_addr_o, RST_PC);

    m_cur.pc   = RST_PC;
    m_cur.slot = 1'b0;
    exp_q.push_back(m_cur);
    rst_n   = 1'b1;
    running = 1'b1;
    #1;
    check32("first_req", {31'd0, inst_req_o}, 32'h1);
    check32("first_addr", inst_addr_o, RST_PC);

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      calm = (cyc < 40);
      // Bus bookkeeping for the edge just taken.
      if (inst_data_ok_i) begin
        out_valid = 1'b0;
      end else if (out_valid && out_lat > 0) begin
        out_lat--;
      end
      if (inst_addr_ok_i) begin
        out_valid = 1'b1;
        out_addr  = acc_addr;
        out_lat   = calm ? 0 : $urandom_range(0, 3);
      end

      if (inst_req_o) begin
        n_checks++;
        if (out_valid) begin
          n_fail++;
          $display("FAIL single_outstanding: request at %h while %h outstanding", inst_addr_o, out_addr);
        end
      end

      inst_data_ok_i = out_valid && (out_lat == 0);
      inst_rdata_i   = inst_data_ok_i ? mem_word(out_addr) : $urandom();
      inst_addr_ok_i = inst_req_o && !out_valid && (calm || ($urandom_range(0, 9) < 6));
      acc_addr       = inst_addr_o;

      if (calm) begin
        if_stall_i = 1'b0;
      end else if (stall_left > 0) begin
        if_stall_i = 1'b1;
        stall_left--;
      end else if ($urandom_range(0, 9) < 2) begin
        if_stall_i = 1'b1;
        stall_left = $urandom_range(0, 3);
      end else begin
        if_stall_i = 1'b0;
      end

      if_flush_i = !calm && ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 3))
        0:       fpc = 32'hBFC0_0380;
        1:       fpc = 32'hFFFF_FFFC;
        default: fpc = RST_PC + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      if_flush_pc_i = if_flush_i ? fpc : $urandom();

      // Decoder behaviour, driven from the instruction ID currently holds.
      if (if_valid_o) begin
        if_next_inslot_i = !if_inslot_o && is_branch(if_inst_o);
        if_branch_en_i   = if_next_inslot_i && is_taken(if_inst_o);
        if_branch_pc_i   = target_of(if_inst_o);
      end else begin
        if_next_inslot_i = 1'($urandom_range(0, 1));
        if_branch_en_i   = 1'($urandom_range(0, 1));
        if_branch_pc_i   = $urandom();
      end

      // Reference program order: branch, delay slot, then target (or fall-through).
      if (if_flush_i) begin
        exp_q.delete();
        m_cur.pc   = fpc;
        m_cur.slot = 1'b0;
        exp_q.push_back(m_cur);
      end else if (if_valid_o && !if_stall_i) begin
        w = mem_word(m_cur.pc);
        if (!m_cur.slot && is_branch(w)) begin
          m_after  = is_taken(w) ? target_of(w) : m_cur.pc + 32'd8;
          nxt.pc   = m_cur.pc + 32'd4;
          nxt.slot = 1'b1;
        end else if (m_cur.slot) begin
          nxt.pc   = m_after;
          nxt.slot = 1'b0;
        end else begin
          nxt.pc   = m_cur.pc + 32'd4;
          nxt.slot = 1'b0;
        end
        exp_q.push_back(nxt);
        m_cur = nxt;
      end

      @(posedge clk);
      #1;
    end

    running = 1'b0;
    check32("liveness_consumed_min", (n_consumed >= 500) ? 32'h1 : 32'h0, 32'h1);
    check32("scoreboard_depth", exp_q.size(), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
